// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - RV32 writeback stage driving the register-file write port
// Optional WB_FWD_EN publishes the in-flight result for EX-stage forwarding.
module writeback_stage #(
  parameter int TIMEOUT_CYC = 16,
  parameter int TO_W        = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic        m_regwrite,
  input  logic [4:0]  m_rd,
  input  logic [1:0]  m_result_src,
  input  logic [31:0] m_alu_result,
  input  logic [31:0] m_pc_plus4,
  input  logic [2:0]  m_funct3,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic        wb_err
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [4:0]      ld_rd;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_addr;
  logic            ld_we;

  function automatic logic load_ok(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: load_ok = 1'b1;
      3'b001, 3'b101: load_ok = ~a[0];
      3'b010:         load_ok = (a == 2'b00);
      default:        load_ok = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'b0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'b0, h};
      default: load_ext = w;
    endcase
  endfunction

  assign m_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      to_cnt  <= '0;
      ld_rd   <= '0;
      ld_f3   <= '0;
      ld_addr <= '0;
      ld_we   <= 1'b0;
      WE3     <= 1'b0;
      A3      <= '0;
      WD3     <= '0;
      wb_err  <= 1'b0;
    end else begin
      WE3 <= 1'b0;
      case (state)
        IDLE: begin
          // Any rvalid seen here, including in a load's own transfer cycle, is stray.
          if (dmem_rvalid) wb_err <= 1'b1;
          if (m_valid) begin
            case (m_result_src)
              2'b00, 2'b10: begin
                if (m_regwrite && (m_rd != 5'd0)) begin
                  WE3 <= 1'b1;
                  A3  <= m_rd;
                  WD3 <= (m_result_src == 2'b00) ? m_alu_result : m_pc_plus4;
                end
              end
              2'b01: begin
                ld_rd   <= m_rd;
                ld_f3   <= m_funct3;
                ld_addr <= m_alu_result[1:0];
                ld_we   <= m_regwrite && (m_rd != 5'd0);
                to_cnt  <= '0;
                state   <= WAIT_LOAD;
              end
              default: ;
            endcase
          end
        end
        WAIT_LOAD: begin
          if (dmem_rvalid) begin
            if (!load_ok(ld_f3, ld_addr)) begin
              wb_err <= 1'b1;
            end else if (ld_we) begin
              WE3 <= 1'b1;
              A3  <= ld_rd;
              WD3 <= load_ext(ld_f3, ld_addr, dmem_rdata);
            end
            to_cnt <= '0;
            state  <= IDLE;
          end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            wb_err <= 1'b1;
            to_cnt <= '0;
            state  <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_FWD_EN
  // While a load is outstanding the consumer must stall on ld_rd.
  assign fwd_valid = WE3;
  assign fwd_rd    = (state == WAIT_LOAD) ? ld_rd : A3;
  assign fwd_data  = WD3;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = 5'd0;
  assign fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid, m_ready, m_regwrite;
  logic [4:0]  m_rd;
  logic [1:0]  m_result_src;
  logic [31:0] m_alu_result, m_pc_plus4;
  logic [2:0]  m_funct3;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        wb_err;

  int checks = 0;
  int errors = 0;
  logic we_seen;

  always #5 clk = ~clk;

  writeback_stage #(.TIMEOUT_CYC(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready),
    .m_regwrite(m_regwrite), .m_rd(m_rd), .m_result_src(m_result_src),
    .m_alu_result(m_alu_result), .m_pc_plus4(m_pc_plus4), .m_funct3(m_funct3),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .wb_err(wb_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] src,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
    m_valid = 1'b1; m_regwrite = rw; m_rd = rd; m_result_src = src;
    m_alu_result = alu; m_pc_plus4 = pc4; m_funct3 = f3;
  endtask

  task automatic idle_in();
    m_valid = 1'b0; m_regwrite = 1'b0; m_rd = '0; m_result_src = '0;
    m_alu_result = '0; m_pc_plus4 = '0; m_funct3 = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    idle_in();
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    rst = 1'b0;
    step(); step();
    chk("rst_we3", {31'b0, WE3}, 32'd0);
    chk("rst_a3", {27'b0, A3}, 32'd0);
    chk("rst_wd3", WD3, 32'd0);
    chk("rst_err", {31'b0, wb_err}, 32'd0);
    chk("rst_fwd", {31'b0, fwd_valid}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_ready", {31'b0, m_ready}, 32'd1);

    // ALU write, then hold
    issue(1'b1, 5'd5, 2'b00, 32'hDEADBEEF, 32'h0, 3'b0);
    step();
    idle_in();
    chk("alu_we3", {31'b0, WE3}, 32'd1);
    chk("alu_a3", {27'b0, A3}, 32'd5);
    chk("alu_wd3", WD3, 32'hDEADBEEF);
`ifdef WB_FWD_EN
    chk("alu_fwd_valid", {31'b0, fwd_valid}, 32'd1);
    chk("alu_fwd_data", fwd_data, 32'hDEADBEEF);
`else
    chk("alu_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    chk("alu_fwd_data", fwd_data, 32'd0);
`endif
    step();
    chk("alu_pulse", {31'b0, WE3}, 32'd0);
    chk("alu_hold_a3", {27'b0, A3}, 32'd5);
    chk("alu_hold_wd3", WD3, 32'hDEADBEEF);

    // back-to-back
    issue(1'b1, 5'd6, 2'b00, 32'h1, 32'h0, 3'b0);
    step();
    chk("b2b0_a3", {27'b0, A3}, 32'd6);
    chk("b2b0_we3", {31'b0, WE3}, 32'd1);
    issue(1'b1, 5'd7, 2'b00, 32'h2, 32'h0, 3'b0);
    step();
    chk("b2b1_we3", {31'b0, WE3}, 32'd1);
    chk("b2b1_a3", {27'b0, A3}, 32'd7);
    chk("b2b1_wd3", WD3, 32'h2);

    // rd=0, JAL, reserved source
    issue(1'b1, 5'd0, 2'b00, 32'h1234, 32'h0, 3'b0);
    step();
    chk("rd0_we3", {31'b0, WE3}, 32'd0);
    chk("rd0_hold_a3", {27'b0, A3}, 32'd7);
    issue(1'b1, 5'd1, 2'b10, 32'h5555, 32'h104, 3'b0);
    step();
    chk("jal_we3", {31'b0, WE3}, 32'd1);
    chk("jal_a3", {27'b0, A3}, 32'd1);
    chk("jal_wd3", WD3, 32'h104);
    issue(1'b1, 5'd3, 2'b11, 32'h77, 32'h0, 3'b0);
    step();
    chk("src11_we3", {31'b0, WE3}, 32'd0);
    issue(1'b0, 5'd4, 2'b00, 32'h88, 32'h0, 3'b0);
    step();
    idle_in();
    chk("norw_we3", {31'b0, WE3}, 32'd0);

    // LB from byte 3, rvalid three cycles after transfer
    issue(1'b1, 5'd9, 2'b01, 32'h1003, 32'h0, 3'b000);
    step();
    idle_in();
    chk("lb_wait_ready", {31'b0, m_ready}, 32'd0);
    chk("lb_wait_we3", {31'b0, WE3}, 32'd0);
    step();
    step();
    chk("lb_wait2_ready", {31'b0, m_ready}, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0000;
    step();
    dmem_rvalid = 1'b0;
    chk("lb_we3", {31'b0, WE3}, 32'd1);
    chk("lb_a3", {27'b0, A3}, 32'd9);
    chk("lb_wd3", WD3, 32'hFFFFFF80);
    chk("lb_ready", {31'b0, m_ready}, 32'd1);
    step();
    chk("lb_pulse", {31'b0, WE3}, 32'd0);

    // LHU upper half
    issue(1'b1, 5'd10, 2'b01, 32'h2002, 32'h0, 3'b101);
    step();
    idle_in();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_1234;
    step();
    dmem_rvalid = 1'b0;
    chk("lhu_we3", {31'b0, WE3}, 32'd1);
    chk("lhu_wd3", WD3, 32'h0000BEEF);
    chk("lhu_err", {31'b0, wb_err}, 32'd0);

    // misaligned LW
    issue(1'b1, 5'd11, 2'b01, 32'h2001, 32'h0, 3'b010);
    step();
    idle_in();
    chk("lw_mis_wait", {31'b0, m_ready}, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    step();
    dmem_rvalid = 1'b0;
    chk("lw_mis_we3", {31'b0, WE3}, 32'd0);
    chk("lw_mis_err", {31'b0, wb_err}, 32'd1);
    chk("lw_mis_ready", {31'b0, m_ready}, 32'd1);
    chk("lw_mis_hold_wd3", WD3, 32'h0000BEEF);

    // timeout after 16 WAIT_LOAD cycles
    do_reset();
    chk("to_rst_err", {31'b0, wb_err}, 32'd0);
    issue(1'b1, 5'd12, 2'b01, 32'h3000, 32'h0, 3'b010);
    step();
    idle_in();
    we_seen = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (WE3) we_seen = 1'b1;
      if (i == 15) begin
        chk("to_wait15_ready", {31'b0, m_ready}, 32'd0);
        chk("to_wait15_err", {31'b0, wb_err}, 32'd0);
      end
    end
    chk("to_ready", {31'b0, m_ready}, 32'd1);
    chk("to_err", {31'b0, wb_err}, 32'd1);
    chk("to_no_write", {31'b0, we_seen}, 32'd0);

    // stray rvalid in a load's transfer cycle does not complete it
    do_reset();
    issue(1'b1, 5'd13, 2'b01, 32'h4000, 32'h0, 3'b010);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
    step();
    idle_in();
    dmem_rvalid = 1'b0;
    chk("stray_xfer_err", {31'b0, wb_err}, 32'd1);
    chk("stray_xfer_wait", {31'b0, m_ready}, 32'd0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h2222_2222;
    step();
    dmem_rvalid = 1'b0;
    chk("stray_xfer_we3", {31'b0, WE3}, 32'd1);
    chk("stray_xfer_wd3", WD3, 32'h2222_2222);

    // reset while waiting for a load
    do_reset();
    issue(1'b1, 5'd14, 2'b01, 32'h5000, 32'h0, 3'b010);
    step();
    idle_in();
    step();
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, m_ready}, 32'd1);
    chk("mid_rst_a3", {27'b0, A3}, 32'd0);
    chk("mid_rst_wd3", WD3, 32'h0);
    step();
    rst = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h3333_3333;
    step();
    dmem_rvalid = 1'b0;
    chk("mid_rst_we3", {31'b0, WE3}, 32'd0);
    chk("mid_rst_wd3_after", WD3, 32'h0);
    chk("mid_rst_err", {31'b0, wb_err}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
